// File: rtl/pipeline_elastic.sv
// -----------------------------------------------------------------------------
// pipeline_elastic
//   Multi-stage pipeline register with a valid/ready handshake at every stage.
//   Each stage stalls under backpressure, and an empty stage (bubble) accepts
//   new data even when the stage below it is stalled, so gaps close while
//   the output is blocked. Throughput is one word per cycle. With ENABLE=0 the
//   block is a combinational pass-through and holds no registers.
//
// Parameters
//   WIDTH   payload width in bits
//   DEPTH   number of register stages (>=1)
//   ENABLE  1: registered stages, 0: combinational pass-through (DEPTH ignored)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears all stages)
//   in_valid   upstream word present on in_data
//   in_ready   block accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload from the last stage
//   occupancy  number of valid stages
//   flush      synchronous, active-high stage clear (PIPE_FLUSH_EN only)
//
// Build option
//   PIPE_FLUSH_EN  when defined, adds the flush input. On an edge with
//                  flush=1 every stage is invalidated, data registers keep
//                  their contents and a word offered in that cycle is dropped.
//                  rst takes priority over flush.
// -----------------------------------------------------------------------------
module pipeline_elastic #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int ENABLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  localparam int OW = $clog2(DEPTH + 1);

  if (ENABLE != 0) begin : g_pipe
    logic [DEPTH-1:0] v;               // stage valid bits, [DEPTH-1] is the output stage
    logic [WIDTH-1:0] d [DEPTH];       // stage data
    logic [DEPTH:0]   rdy;             // rdy[i]: stage i may load this edge
    logic [DEPTH-1:0] v_up;            // valid offered to stage i from above
    logic [WIDTH-1:0] d_up [DEPTH];    // data offered to stage i from above
    logic             flush_i;
    logic [OW-1:0]    cnt;

`ifdef PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // A stage can load when it is empty or when the stage below it is moving,
    // which is what lets bubbles collapse under backpressure.
    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      assign rdy[i] = !v[i] || rdy[i+1];
      if (i == 0) begin : g_first
        assign v_up[i] = in_valid;
        assign d_up[i] = in_data;
      end else begin : g_rest
        assign v_up[i] = v[i-1];
        assign d_up[i] = d[i-1];
      end
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of the stage above it; blocking assignments
    // here would ripple one word through several stages in a single edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= '0;
        // NOTE: the data registers are reset as well because out_data must
        // read zero while in reset; a plain storage array would not need it.
        for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      end else if (flush_i) begin
        v <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rdy[i]) begin
            v[i] <= v_up[i];
            // A bubble moving in clears the valid bit but keeps old data.
            if (v_up[i]) d[i] <= d_up[i];
          end
        end
      end
    end

    // NOTE: cnt is given a default before the loop so the combinational block
    // assigns it on every path and no latch is inferred.
    always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + OW'(v[i]);
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = cnt;
  end else begin : g_bypass
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign occupancy = '0;
  end

endmodule

// File: tb/tb_pipeline_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipeline_elastic
//   Directed bench for pipeline_elastic. Three instances share clk/rst:
//     u3  DEPTH=3  streaming, backpressure, reset mid-operation, flush
//     u4  DEPTH=4  bubble collapse
//     u0  ENABLE=0 combinational pass-through
//   Expected values are hand-derived constants and cycle indices.
// -----------------------------------------------------------------------------
module tb_pipeline_elastic;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // u3 signals
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic        a_flush;
  // u4 signals
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [2:0]  b_occ;
  // u0 signals
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_occ;

  pipeline_elastic #(.WIDTH(32), .DEPTH(3), .ENABLE(1)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
`ifdef PIPE_FLUSH_EN
    , .flush(a_flush)
`endif
  );

  pipeline_elastic #(.WIDTH(32), .DEPTH(4), .ENABLE(1)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
`ifdef PIPE_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  pipeline_elastic #(.WIDTH(32), .DEPTH(2), .ENABLE(0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ)
`ifdef PIPE_FLUSH_EN
    , .flush(1'b1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ENABLE=0 vectors: {in_valid, out_ready, in_data}
  logic        pv_valid [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        pv_ready [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] pv_data  [4] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_flush = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 0;

    // ---------------- reset state ----------------
    #12;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data",  a_out_data,       32'd0);
    check("rst_occ",       32'(a_occ),       32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_occ_d4",    32'(b_occ),       32'd0);
    rst = 1'b0;
    step();

    // ---------------- streaming, DEPTH=3 ----------------
    // Word k+1 accepted at edge k appears after edge k+2.
    a_out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      a_in_valid = (c < 10);
      a_in_data  = 32'(c + 1);
      #1;
      check($sformatf("stream_in_ready_%0d", c), 32'(a_in_ready), 32'd1);
      step();
      check($sformatf("stream_valid_%0d", c), 32'(a_out_valid),
            ((c >= 2) && (c < 12)) ? 32'd1 : 32'd0);
      if ((c >= 2) && (c < 12))
        check($sformatf("stream_data_%0d", c), a_out_data, 32'(c - 1));
    end
    a_in_valid = 1'b0;
    check("stream_empty_occ", 32'(a_occ), 32'd0);

    // ---------------- backpressure, DEPTH=3 ----------------
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA; #1;
    check("bp_ready_a", 32'(a_in_ready), 32'd1);
    step();
    a_in_data   = 32'hB; #1;
    check("bp_ready_b", 32'(a_in_ready), 32'd1);
    step();
    a_in_data   = 32'hC; #1;
    check("bp_ready_c", 32'(a_in_ready), 32'd1);
    step();
    check("bp_full_occ",   32'(a_occ),       32'd3);
    check("bp_full_valid", 32'(a_out_valid), 32'd1);
    check("bp_full_data",  a_out_data,       32'hA);
    a_in_data   = 32'hD; #1;
    check("bp_full_ready", 32'(a_in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_data_%0d", k),  a_out_data,       32'hA);
      check($sformatf("bp_hold_valid_%0d", k), 32'(a_out_valid), 32'd1);
      check($sformatf("bp_hold_occ_%0d", k),   32'(a_occ),       32'd3);
      check($sformatf("bp_hold_ready_%0d", k), 32'(a_in_ready),  32'd0);
    end
    a_out_ready = 1'b1; #1;
    check("bp_release_ready", 32'(a_in_ready), 32'd1);
    check("bp_release_data",  a_out_data,      32'hA);
    step();                                   // A leaves, D enters
    a_in_valid = 1'b0;
    check("bp_out_b",   a_out_data,  32'hB);
    check("bp_occ_b",   32'(a_occ),  32'd3);
    step();
    check("bp_out_c",   a_out_data,  32'hC);
    check("bp_occ_c",   32'(a_occ),  32'd2);
    step();
    check("bp_out_d",   a_out_data,  32'hD);
    check("bp_occ_d",   32'(a_occ),  32'd1);
    step();
    check("bp_drained_valid", 32'(a_out_valid), 32'd0);
    check("bp_drained_occ",   32'(a_occ),       32'd0);

    // ---------------- bubble collapse, DEPTH=4 ----------------
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1; b_in_data = 32'h1;
    step();
    b_in_valid  = 1'b0;
    step();
    step();
    b_in_valid  = 1'b1; b_in_data = 32'h2;
    step();
    b_in_valid  = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("bub_occ",      32'(b_occ),       32'd2);
    check("bub_valid",    32'(b_out_valid), 32'd1);
    check("bub_data",     b_out_data,       32'h1);
    check("bub_in_ready", 32'(b_in_ready),  32'd1);
    b_out_ready = 1'b1;
    step();
    check("bub_second_valid", 32'(b_out_valid), 32'd1);
    check("bub_second_data",  b_out_data,       32'h2);
    step();
    check("bub_done_valid",   32'(b_out_valid), 32'd0);
    check("bub_done_occ",     32'(b_occ),       32'd0);

    // ---------------- reset mid-operation, DEPTH=3 ----------------
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = 32'h11;
    step();
    a_in_data   = 32'h22;
    step();
    a_in_valid  = 1'b0;
    check("mrst_pre_occ", 32'(a_occ), 32'd2);
    #3 rst = 1'b1;                            // between edges
    #1;
    check("mrst_occ",      32'(a_occ),       32'd0);
    check("mrst_valid",    32'(a_out_valid), 32'd0);
    check("mrst_data",     a_out_data,       32'd0);
    check("mrst_in_ready", 32'(a_in_ready),  32'd1);
    #1 rst = 1'b0;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1; a_in_data = 32'h55;
    step();
    a_in_valid  = 1'b0;
    check("mrst_no_stale_0", 32'(a_out_valid), 32'd0);
    step();
    check("mrst_no_stale_1", 32'(a_out_valid), 32'd0);
    step();
    check("mrst_first_valid", 32'(a_out_valid), 32'd1);
    check("mrst_first_data",  a_out_data,       32'h55);
    step();
    check("mrst_after_valid", 32'(a_out_valid), 32'd0);

    // ---------------- ENABLE=0 pass-through ----------------
    for (int k = 0; k < 4; k++) begin
      c_in_valid  = pv_valid[k];
      c_out_ready = pv_ready[k];
      c_in_data   = pv_data[k];
      #1;
      check($sformatf("pt_valid_%0d", k), 32'(c_out_valid), 32'(pv_valid[k]));
      check($sformatf("pt_ready_%0d", k), 32'(c_in_ready),  32'(pv_ready[k]));
      check($sformatf("pt_data_%0d", k),  c_out_data,       pv_data[k]);
      check($sformatf("pt_occ_%0d", k),   32'(c_occ),       32'd0);
    end

`ifdef PIPE_FLUSH_EN
    // ---------------- flush, DEPTH=3 ----------------
    step();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = 32'h66;
    step();
    a_in_data   = 32'h67;
    step();
    check("fl_pre_occ", 32'(a_occ), 32'd2);
    a_flush     = 1'b1;
    a_in_data   = 32'h77; #1;
    check("fl_in_ready", 32'(a_in_ready), 32'd1);
    step();
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    check("fl_occ",   32'(a_occ),       32'd0);
    check("fl_valid", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("fl_dropped_%0d", k), 32'(a_out_valid), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
